uart_echo_ctrl: RTL and testbench

Parametrised echo controller between the UART receive and transmit FIFO ports on the board-level loopback build. It pops received words, applies a run-time-selectable transform, and pushes the result into the transmit FIFO. Two pacing modes: free-running, or one word per debounced button tick. It reports the last echoed word and a running echo count for the LED and seven-segment displays.

---
 rtl/uart_echo_ctrl.sv | 139 +++++++++++++
 tb/tb_uart_echo_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_ctrl.sv
// uart_echo_ctrl
//   Echo controller between the UART receive and transmit FIFO ports.
//   It pops one received word, applies a run-time-selectable transform and
//   pushes the result into the transmit FIFO. Pacing is either free-running
//   (i_auto = 1) or one word per debounced button tick (i_step).
//
// Ports
//   clk       system clock, all state on the rising edge
//   reset     asynchronous active-low reset
//   i_mode    transform: 0 pass, 1 increment, 2 invert, 3 ASCII case swap
//   i_auto    1 = echo whenever data is available, 0 = step mode
//   i_step    single-cycle tick granting one echo in step mode
//   rx_empty  receive FIFO empty
//   r_data    head of the receive FIFO (valid while rx_empty = 0)
//   rd_uart   pop strobe to the receive FIFO
//   tx_full   transmit FIFO full
//   wr_uart   push strobe to the transmit FIFO
//   w_data    word being pushed
//   o_last    last word pushed
//   o_count   number of words pushed, modulo 2^CNT_W
//   o_busy    high whenever a word is in flight
module uart_echo_ctrl #(
  parameter int DBIT  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       i_mode,
  input  logic             i_auto,
  input  logic             i_step,
  input  logic             rx_empty,
  input  logic [DBIT-1:0]  r_data,
  output logic             rd_uart,
  input  logic             tx_full,
  output logic             wr_uart,
  output logic [DBIT-1:0]  w_data,
  output logic [DBIT-1:0]  o_last,
  output logic [CNT_W-1:0] o_count,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_XFORM   = 2'd1,
    S_WAIT_TX = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_step_pend;
  logic [DBIT-1:0] r_rx;
  logic [1:0]      r_mode;
  logic [DBIT-1:0] r_tx;
  logic            w_go;

  // ASCII letter test; narrower words cannot hold a letter code.
  function automatic logic f_is_alpha(input logic [DBIT-1:0] x);
    logic res;
    res = 1'b0;
    if (DBIT >= 7) begin
      res = ((x >= DBIT'(8'h41)) && (x <= DBIT'(8'h5A))) ||
            ((x >= DBIT'(8'h61)) && (x <= DBIT'(8'h7A)));
    end
    return res;
  endfunction

  function automatic logic [DBIT-1:0] f_xform(input logic [1:0]      mode,
                                              input logic [DBIT-1:0] x);
    logic [DBIT-1:0] y;
    y = x;
    case (mode)
      2'd0:    y = x;
      2'd1:    y = x + DBIT'(1);
      2'd2:    y = ~x;
      default: if (f_is_alpha(x)) y = x ^ DBIT'(8'h20);
    endcase
    return y;
  endfunction

  // Gating with reset keeps the pop strobe low while reset is held even
  // though the FIFO may already be presenting data.
  assign w_go = reset && !rx_empty && (i_auto || r_step_pend);

  always_comb begin
    w_state_nxt = r_state;
    rd_uart     = 1'b0;
    wr_uart     = 1'b0;
    case (r_state)
      S_IDLE: begin
        rd_uart = w_go;
        if (w_go) w_state_nxt = S_XFORM;
      end
      S_XFORM: w_state_nxt = S_WAIT_TX;
      S_WAIT_TX: begin
        wr_uart = !tx_full;
        if (!tx_full) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (!reset) begin
      rd_uart = 1'b0;
      wr_uart = 1'b0;
    end
  end

  // Control state and visible outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_step_pend <= 1'b0;
      r_tx        <= '0;
      o_last      <= '0;
      o_count     <= '0;
    end else begin
      r_state <= w_state_nxt;
      // A pop consumes the pending tick, including one arriving on the same edge.
      if (rd_uart)     r_step_pend <= 1'b0;
      else if (i_step) r_step_pend <= 1'b1;
      if (r_state == S_XFORM) r_tx <= f_xform(r_mode, r_rx);
      if (wr_uart) begin
        o_last  <= r_tx;
        o_count <= o_count + CNT_W'(1);
      end
    end
  end

  // Pop stage: word and mode are captured together so mode changes only
  // affect later words.
  always_ff @(posedge clk) begin
    if (rd_uart) begin
      r_rx   <= r_data;
      r_mode <= i_mode;
    end
  end

  assign w_data = r_tx;
  assign o_busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_echo_ctrl.sv
module tb_uart_echo_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] i_mode;
  logic       i_auto;
  logic       i_step;
  logic       rx_empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       rd_uart;
  logic       tx_full;
  logic       wr_uart;
  logic [7:0] w_data;
  logic [7:0] o_last;
  logic [3:0] o_count;
  logic       o_busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] rxq[$];
  logic [7:0] expq[$];
  logic [7:0] pushlog[$];
  int         popcyc[$];
  int         cyc = 0;
  int         pop_cnt = 0;
  int         push_cnt = 0;
  bit         pop_pend = 1'b0;

  uart_echo_ctrl #(.DBIT(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .i_mode(i_mode), .i_auto(i_auto), .i_step(i_step),
    .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart), .tx_full(tx_full),
    .wr_uart(wr_uart), .w_data(w_data), .o_last(o_last), .o_count(o_count),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mdl(input logic [1:0] m, input logic [7:0] x);
    case (m)
      2'd0: return x;
      2'd1: return x + 8'd1;
      2'd2: return ~x;
      default: begin
        if ((x >= 8'h41 && x <= 8'h5A) || (x >= 8'h61 && x <= 8'h7A)) return x ^ 8'h20;
        return x;
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Receive FIFO model: updates after the stimulus has settled each cycle.
  always @(posedge clk) begin
    #2;
    if (pop_pend) begin
      void'(rxq.pop_front());
      pop_pend = 1'b0;
    end
    rx_empty = (rxq.size() == 0);
    r_data   = rx_empty ? 8'h00 : rxq[0];
  end

  // Scoreboard: expected word queued at pop, compared at push.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      chk("strobe_excl", {31'd0, rd_uart & wr_uart}, 32'd0);
      if (rd_uart) begin
        expq.push_back(mdl(i_mode, r_data));
        pop_pend = 1'b1;
        pop_cnt++;
        popcyc.push_back(cyc);
      end
      if (wr_uart) begin
        push_cnt++;
        pushlog.push_back(w_data);
        if (expq.size() == 0) chk("sb_underflow", 32'(expq.size()), 32'd1);
        else chk("sb_push", {24'd0, w_data}, {24'd0, expq.pop_front()});
      end
    end
  end

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pushes(input int n, input int budget);
    int k = 0;
    while (push_cnt < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("push_wait", push_cnt, n);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_pop(input int budget);
    int k = 0;
    @(negedge clk);
    while (!rd_uart && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("pop_seen", {31'd0, rd_uart}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, q0, b;
    // Reset held with data available and auto mode on.
    reset = 1'b0; i_mode = 2'd1; i_auto = 1'b1; i_step = 1'b0; tx_full = 1'b0;
    rxq.push_back(8'h41); rxq.push_back(8'hFF); rxq.push_back(8'h7E);
    repeat (3) @(negedge clk);
    chk("rst_rd", {31'd0, rd_uart}, 32'd0);
    chk("rst_wr", {31'd0, wr_uart}, 32'd0);
    chk("rst_wdata", {24'd0, w_data}, 32'd0);
    chk("rst_last", {24'd0, o_last}, 32'd0);
    chk("rst_count", {28'd0, o_count}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    cyc1();
    reset = 1'b1;
    @(negedge clk);
    chk("rd_after_rst", {31'd0, rd_uart}, 32'd1);

    // Auto increment.
    wait_pushes(3, 40);
    chk("inc_0", {24'd0, pushlog[0]}, 32'h42);
    chk("inc_1", {24'd0, pushlog[1]}, 32'h00);
    chk("inc_2", {24'd0, pushlog[2]}, 32'h7F);
    chk("pop_gap_a", popcyc[1] - popcyc[0], 3);
    chk("pop_gap_b", popcyc[2] - popcyc[1], 3);
    chk("inc_count", {28'd0, o_count}, 32'd3);
    chk("inc_last", {24'd0, o_last}, 32'h7F);

    // Step mode: two consecutive ticks grant one word.
    cyc1();
    i_auto = 1'b0; i_mode = 2'd0;
    rxq.push_back(8'h10); rxq.push_back(8'h11);
    repeat (3) cyc1();
    p0 = pop_cnt; q0 = push_cnt;
    i_step = 1'b1; cyc1(); cyc1(); i_step = 1'b0;
    repeat (8) cyc1();
    chk("step_pops1", pop_cnt, p0 + 1);
    chk("step_push1", push_cnt, q0 + 1);
    chk("step_val1", {24'd0, pushlog[pushlog.size()-1]}, 32'h10);
    chk("step_left", 32'(rxq.size()), 32'd1);
    i_step = 1'b1; cyc1(); i_step = 1'b0;
    repeat (6) cyc1();
    chk("step_pops2", pop_cnt, p0 + 2);
    chk("step_val2", {24'd0, pushlog[pushlog.size()-1]}, 32'h11);
    // Tick while empty stays pending until data arrives.
    i_step = 1'b1; cyc1(); i_step = 1'b0;
    repeat (5) cyc1();
    chk("pend_nopop", pop_cnt, p0 + 2);
    chk("pend_idle", {31'd0, o_busy}, 32'd0);
    rxq.push_back(8'h22);
    repeat (6) cyc1();
    chk("pend_pop", pop_cnt, p0 + 3);
    chk("pend_val", {24'd0, pushlog[pushlog.size()-1]}, 32'h22);

    // Case swap.
    i_mode = 2'd3; i_auto = 1'b1;
    q0 = push_cnt;
    rxq.push_back(8'h61); rxq.push_back(8'h5A); rxq.push_back(8'h40); rxq.push_back(8'h7B);
    wait_pushes(q0 + 4, 40);
    b = pushlog.size() - 4;
    chk("swap_61", {24'd0, pushlog[b]}, 32'h41);
    chk("swap_5A", {24'd0, pushlog[b+1]}, 32'h7A);
    chk("swap_40", {24'd0, pushlog[b+2]}, 32'h40);
    chk("swap_7B", {24'd0, pushlog[b+3]}, 32'h7B);

    // Mode change in the XFORM cycle affects only the next word.
    cyc1();
    q0 = push_cnt;
    rxq.push_back(8'h61); rxq.push_back(8'h62);
    wait_pop(20);
    cyc1();
    i_mode = 2'd2;
    wait_pushes(q0 + 2, 30);
    b = pushlog.size() - 2;
    chk("midmode_swap", {24'd0, pushlog[b]}, 32'h41);
    chk("midmode_inv", {24'd0, pushlog[b+1]}, 32'h9D);

    // Backpressure stall.
    cyc1();
    i_mode = 2'd0; tx_full = 1'b1;
    q0 = push_cnt;
    rxq.push_back(8'h33); rxq.push_back(8'h34);
    wait_pop(20);
    cyc1();
    cyc1();
    p0 = pop_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_wr", {31'd0, wr_uart}, 32'd0);
      chk("stall_wdata", {24'd0, w_data}, 32'h33);
    end
    chk("stall_nopop", pop_cnt, p0);
    cyc1();
    tx_full = 1'b0;
    @(negedge clk);
    chk("release_wr", {31'd0, wr_uart}, 32'd1);
    cyc1();
    @(negedge clk);
    chk("release_single", {31'd0, wr_uart}, 32'd0);
    wait_pushes(q0 + 2, 20);
    chk("release_next", {24'd0, pushlog[pushlog.size()-1]}, 32'h34);

    // Reset during a stall discards the in-flight word.
    cyc1();
    tx_full = 1'b1;
    rxq.push_back(8'h55);
    wait_pop(20);
    repeat (4) cyc1();
    q0 = push_cnt;
    reset = 1'b0;
    expq.delete();
    cyc1(); cyc1();
    reset = 1'b1; tx_full = 1'b0;
    repeat (8) cyc1();
    chk("rststall_nopush", push_cnt, q0);
    chk("rststall_count", {28'd0, o_count}, 32'd0);
    chk("rststall_busy", {31'd0, o_busy}, 32'd0);

    // Counter wrap with a 4-bit counter.
    q0 = push_cnt;
    for (int i = 0; i < 17; i++) rxq.push_back(8'(i * 7 + 3));
    wait_pushes(q0 + 17, 120);
    chk("wrap_count", {28'd0, o_count}, 32'd1);
    chk("wrap_last", {24'd0, o_last}, 32'(8'(16 * 7 + 3)));
    chk("sb_drained", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
